// File: rtl/interrupt_ctrl.sv
// Interrupt code generator for the core decoder: timed RESET pulse, auto-expiring
// PAUSE and latched STOP. Runs on the ungated reference clock.
module interrupt_ctrl #(
    parameter int                  DATA_WIDTH      = 8,
    parameter int                  RESET_CYCLES    = 4,
    parameter int                  PAUSE_CYCLES    = 16,
    parameter logic [DATA_WIDTH-1:0] INTERRUPT_RESET = 8'h01,
    parameter logic [DATA_WIDTH-1:0] INTERRUPT_STOP  = 8'h02,
    parameter logic [DATA_WIDTH-1:0] INTERRUPT_PAUSE = 8'h03
) (
    input  logic                  ref_clk,
    input  logic                  chip_rst_n,
    input  logic                  req_reset,
    input  logic                  req_stop,
    input  logic                  req_pause,
    input  logic                  resume,
    output logic [DATA_WIDTH-1:0] interrupt,
    output logic                  busy,
    output logic [1:0]            state
);

    localparam int MAX_CYCLES = (RESET_CYCLES > PAUSE_CYCLES) ? RESET_CYCLES : PAUSE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [DATA_WIDTH-1:0] INTERRUPT_NONE = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]      RESET_LOAD     = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]      PAUSE_LOAD     = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RESET = 2'b01,
        ST_STOP  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_interrupt;
    logic                    r_busy;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    // Outputs are decoded from the next state so they register alongside it.
    function automatic logic [DATA_WIDTH-1:0] decode_code(input state_t st);
        logic [DATA_WIDTH-1:0] code;
        case (st)
            ST_IDLE:  code = INTERRUPT_NONE;
            ST_RESET: code = INTERRUPT_RESET;
            ST_STOP:  code = INTERRUPT_STOP;
            ST_PAUSE: code = INTERRUPT_PAUSE;
            default:  code = INTERRUPT_NONE;
        endcase
        return code;
    endfunction

    // Next-state and counter logic; requests are prioritised and never queued.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_reset) begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = RESET_LOAD;
                end else if (req_stop) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (req_pause) begin
                    w_state_nxt = ST_PAUSE;
                    w_cnt_nxt   = PAUSE_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_RESET: begin
                if (req_reset) begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = RESET_LOAD;
                end else if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (req_reset) begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = RESET_LOAD;
                end else if (resume) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_PAUSE: begin
                if (req_reset) begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = RESET_LOAD;
                end else if (req_stop) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (req_pause) begin
                    w_state_nxt = ST_PAUSE;
                    w_cnt_nxt   = PAUSE_LOAD;
                end else if (resume || (r_cnt == CNT_ZERO)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_PAUSE;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; chip reset aborts any sequence.
    always_ff @(posedge ref_clk) begin
        if (!chip_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_interrupt <= INTERRUPT_NONE;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_interrupt <= decode_code(w_state_nxt);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign interrupt = r_interrupt;
    assign busy      = r_busy;
    assign state     = r_state;

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Generates the `DATA_WIDTH`-bit interrupt code consumed by the core decoder. That decoder gates the core clock on STOP/PAUSE and asserts core reset on RESET. This block turns external request lines into timed, prioritised interrupt codes: a stretched reset pulse, an auto-expiring pause, and a latched stop released by `resume`. It runs on the ungated `ref_clk`, so it keeps working while the core clock is held low.

## Interface
- `RESET_CYCLES`, default 4: number of `ref_clk` cycles `INTERRUPT_RESET` is driven per reset request; minimum 1.
- `PAUSE_CYCLES`, default 16: maximum number of `ref_clk` cycles `INTERRUPT_PAUSE` is driven per pause request; minimum 1.
- `ref_clk`  in  1  chip reference clock, the block's only clock.
- `chip_rst_n`  in  1  synchronous, active-low reset.
- `req_reset`  in  1  core reset request; sampled each edge; a 1-cycle pulse suffices.
- `req_stop`  in  1  stop request; sampled each edge.
- `req_pause`  in  1  pause request; sampled each edge.
- `resume`  in  1  releases STOP or PAUSE early.
- `interrupt`  out  `DATA_WIDTH`  registered interrupt code to the decoder.
- `busy`  out  1  registered; high in any state other than IDLE.
- `state`  out  2  registered state: IDLE=00, RESET=01, STOP=10, PAUSE=11.

## Operation
- Codes come from define.v: `INTERRUPT_RESET`, `INTERRUPT_STOP`, `INTERRUPT_PAUSE`. This block adds `INTERRUPT_NONE` = `DATA_WIDTH'h00`, distinct from all three.
- `interrupt` is a pure function of the state register: IDLE→NONE, RESET→RESET, STOP→STOP, PAUSE→PAUSE.
- Down-counter `cnt`, width `$clog2(max(RESET_CYCLES, PAUSE_CYCLES)+1)`. It is loaded on entry to RESET or PAUSE and decrements once per cycle in those states.
- Request priority, evaluated every cycle: `req_reset` > `req_stop` > `req_pause` > `resume`.
- IDLE:
  - `req_reset` → RESET, `cnt`=RESET_CYCLES-1.
  - else `req_stop` → STOP.
  - else `req_pause` → PAUSE, `cnt`=PAUSE_CYCLES-1.
  - `resume` alone is ignored.
- RESET:
  - `req_reset` reloads `cnt`=RESET_CYCLES-1 (extends the pulse).
  - else if `cnt`==0 → IDLE.
  - else `cnt`-1.
  - `req_stop`, `req_pause` and `resume` are ignored and dropped, not queued.
- STOP:
  - `req_reset` → RESET (load).
  - else `resume` → IDLE.
  - otherwise stay; stop and pause requests are ignored. No timeout.
- PAUSE:
  - `req_reset` → RESET (load).
  - else `req_stop` → STOP (escalation).
  - else `req_pause` reloads `cnt`=PAUSE_CYCLES-1.
  - else `resume` → IDLE.
  - else if `cnt`==0 → IDLE.
  - else `cnt`-1.
- Requests are never queued; only the highest-priority request in a cycle acts.

## Timing
- Reset (`chip_rst_n`=0 at an edge): state=IDLE, `cnt`=0, `interrupt`=`INTERRUPT_NONE`, `busy`=0, `state`=00. Reset mid-RESET/STOP/PAUSE aborts immediately to these values with no completion.
- Latency: a request sampled at edge k changes `interrupt`, `busy` and `state` right after edge k, so they are visible through cycle k+1.
- RESET pulse width: exactly RESET_CYCLES cycles of `INTERRUPT_RESET`, then NONE, unless another request is present.
- PAUSE width: exactly PAUSE_CYCLES cycles if undisturbed. `resume` sampled at edge k gives NONE after edge k.
- Back-to-back: a request sampled on the final RESET/PAUSE cycle (`cnt`==0) is ignored, except `req_reset` in RESET (reload) and `req_reset`/`req_stop`/`req_pause` in PAUSE, which act per the transition rules. IDLE is otherwise held for at least one cycle.
- Simultaneous `resume` and `req_reset` → RESET. Simultaneous `req_stop` and `req_pause` in IDLE → STOP.

## Test plan
- Release reset; hold all requests at 0 for 10 cycles → `interrupt`=NONE, `busy`=0, `state`=00 throughout.
- 1-cycle `req_reset` at edge 5 (RESET_CYCLES=4) → `INTERRUPT_RESET` after edges 5..8, NONE after edge 9. Repeat with a second `req_reset` at edge 7 → RESET held through edge 10, NONE after edge 11.
- `req_pause` pulse at edge 2 (PAUSE_CYCLES=16) → PAUSE after edges 2..17, IDLE after edge 18. Repeat with `resume` at edge 6 → NONE after edge 6.
- `req_pause` at edge 2, `req_stop` at edge 4 → STOP after edge 4; still STOP 100 cycles later; `resume` at edge 110 → NONE after edge 110.
- In STOP, drive `resume` and `req_reset` together → RESET for 4 cycles, then IDLE. In IDLE, drive `req_stop` and `req_pause` together → STOP.
- Pull `chip_rst_n` low mid-PAUSE (`cnt`=9) for one edge → state 00, NONE, `busy`=0 next cycle; no residual pause after release.
